noc_link_credit_buffer: RTL
===========================

Name: noc_link_credit_buffer

Overview:
Per-port link stage between one router output (send/data/dest/is_tail, credit return) and the next router's input port, in the same flit protocol on both sides. It buffers flits locally and forwards them downstream only while it holds downstream credits. It returns credits upstream as its own buffer drains, and optionally retimes both directions with NUM_PIPELINE register stages. This lets long inter-router links be pipelined without changing router buffer sizing.

Parameters:
FLIT_WIDTH, 32, flit data width
DEST_WIDTH, 6, destination field width (TDEST_WIDTH + TID_WIDTH)
BUFFER_DEPTH, 2, local FIFO entries; equals credits granted to the upstream router
DOWNSTREAM_CREDITS, 2, initial credit count; equals downstream router FLIT_BUFFER_DEPTH
NUM_PIPELINE, 1, register stages on forward path output and on credit_out (0..4)

Ports:
clk_noc  in  1  link clock
rst_n  in  1  synchronous active-low reset
data_in  in  FLIT_WIDTH  upstream flit data
dest_in  in  DEST_WIDTH  upstream flit destination
is_tail_in  in  1  upstream tail marker
send_in  in  1  upstream flit valid (single-cycle per flit)
credit_out  out  1  one-cycle pulse per freed local FIFO entry
data_out  out  FLIT_WIDTH  downstream flit data
dest_out  out  DEST_WIDTH  downstream flit destination
is_tail_out  out  1  downstream tail marker
send_out  out  1  downstream flit valid
credit_in  in  1  one-cycle pulse per freed downstream buffer entry
credit_count  out  $clog2(DOWNSTREAM_CREDITS+1)  current downstream credits
fifo_count  out  $clog2(BUFFER_DEPTH+1)  local FIFO occupancy
overflow_err  out  1  sticky: flit arrived with FIFO full
credit_err  out  1  sticky: credit_in arrived with credit_count == DOWNSTREAM_CREDITS

Behaviour:
- One clock, clk_noc; reset is synchronous, active-low (rst_n sampled on clk_noc rising edge).
- Reset: FIFO empty, fifo_count=0, credit_count=DOWNSTREAM_CREDITS, all pipeline stages cleared. send_out=0, is_tail_out=0, data_out=0, dest_out=0, credit_out=0, overflow_err=0, credit_err=0. Flits and credits in flight at reset are discarded.
- Enqueue: on send_in=1, push {data_in, dest_in, is_tail_in} at the tail. No bypass; a flit written in cycle t is dequeue-eligible from t+1.
- Overflow: if send_in=1 with FIFO full and no same-cycle dequeue, drop the flit and set overflow_err. If a same-cycle dequeue frees an entry, accept the flit; no error.
- Dequeue condition: FIFO non-empty AND registered credit_count > 0. At most one flit per cycle, in strict FIFO order. is_tail is carried unchanged; there is no packet-level gating.
- Dequeue action:
  - Flit enters forward pipeline stage 0; appears on send_out NUM_PIPELINE cycles after the dequeue cycle (NUM_PIPELINE=0: same cycle, combinational from FIFO head).
  - credit_count decrements.
  - A credit pulse enters the credit pipeline; credit_out=1 NUM_PIPELINE cycles after dequeue (0: same cycle).
- credit_in:
  - Increments credit_count.
  - Simultaneous credit_in and dequeue: count unchanged.
  - credit_in at count==DOWNSTREAM_CREDITS with no dequeue: count held, credit_err set.
- A credit arriving in cycle t enables a dequeue in t+1 (no combinational credit_in->send_out path).
- Throughput: sustained 1 flit/cycle when downstream credits return with round-trip latency <= DOWNSTREAM_CREDITS cycles.
- Pipeline stages only carry send/credit pulses and flit payload; when not sending, the stage's send is 0. Data and dest hold their last value.
- fifo_count = pushes - pops, range 0..BUFFER_DEPTH; simultaneous push and pop leaves it unchanged. Read and write pointers wrap modulo BUFFER_DEPTH; non-power-of-2 depth is supported.
- Error flags clear only on reset.

Test Plan:
- Reset then idle 10 cycles -> credit_count=2, fifo_count=0, send_out=0, credit_out=0, both error flags 0.
- NUM_PIPELINE=1: one flit (data=0xA5A5A5A5, dest=6'h05, tail=1) at cycle 0 -> dequeued cycle 1; send_out=1 with the same payload at cycle 2; credit_out pulse at cycle 2; credit_count=1.
- Three back-to-back flits, no credit_in -> first two forwarded, credit_count=0, third held with fifo_count=1. A credit_in pulse at cycle 10 -> third flit dequeued at cycle 11.
- Credit loopback (credit_in = send_out delayed 1 cycle), 100 flits with sequence data -> all delivered in order, no errors, credit_count never below 0 or above 2.
- Hold credit_count=0 and send 3 flits with BUFFER_DEPTH=2 -> third dropped, overflow_err=1, fifo_count=2. Extra credit_in at credit_count=2 -> credit_err=1, count stays 2.
- Assert rst_n=0 for one cycle with 2 flits buffered and 1 in the pipeline -> next cycle send_out=0, fifo_count=0, credit_count=2; no stale flit or credit pulse emitted afterward.

Source files
------------

// File: rtl/noc_link_credit_buffer.sv
// rtl/noc_link_credit_buffer.sv - credit-gated link buffer between two routers
// Local FIFO forwards flits only while downstream credits remain; optional retiming on both directions.
module noc_link_credit_buffer #(
    parameter int FLIT_WIDTH         = 32,
    parameter int DEST_WIDTH         = 6,
    parameter int BUFFER_DEPTH       = 2,
    parameter int DOWNSTREAM_CREDITS = 2,
    parameter int NUM_PIPELINE       = 1
) (
    input  logic                                    clk_noc,
    input  logic                                    rst_n,
    input  logic [FLIT_WIDTH-1:0]                   data_in,
    input  logic [DEST_WIDTH-1:0]                   dest_in,
    input  logic                                    is_tail_in,
    input  logic                                    send_in,
    output logic                                    credit_out,
    output logic [FLIT_WIDTH-1:0]                   data_out,
    output logic [DEST_WIDTH-1:0]                   dest_out,
    output logic                                    is_tail_out,
    output logic                                    send_out,
    input  logic                                    credit_in,
    output logic [$clog2(DOWNSTREAM_CREDITS+1)-1:0] credit_count,
    output logic [$clog2(BUFFER_DEPTH+1)-1:0]       fifo_count,
    output logic                                    overflow_err,
    output logic                                    credit_err
);

    localparam int CW = $clog2(DOWNSTREAM_CREDITS + 1);
    localparam int FW = $clog2(BUFFER_DEPTH + 1);
    localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int EW = FLIT_WIDTH + DEST_WIDTH + 1;
    localparam int PS = (NUM_PIPELINE > 0) ? NUM_PIPELINE : 1;

    logic [EW-1:0] r_mem [BUFFER_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [FW-1:0] r_fifo_count;
    logic [CW-1:0] r_credit_count;
    logic          r_overflow_err;
    logic          r_credit_err;

    logic          w_empty;
    logic          w_full;
    logic          w_deq;
    logic          w_push;
    logic [EW-1:0] w_flit_in;
    logic [EW-1:0] w_head;
    logic [PW-1:0] w_wr_ptr_nxt;
    logic [PW-1:0] w_rd_ptr_nxt;

    assign w_flit_in    = {data_in, dest_in, is_tail_in};
    assign w_head       = r_mem[r_rd_ptr];
    assign w_empty      = (r_fifo_count == '0);
    assign w_full       = (r_fifo_count == FW'(BUFFER_DEPTH));
    // Dequeue looks only at registered state, so credit_in never reaches send_out in the same cycle.
    assign w_deq        = !w_empty && (r_credit_count != '0);
    assign w_push       = send_in && (!w_full || w_deq);
    assign w_wr_ptr_nxt = (r_wr_ptr == PW'(BUFFER_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == PW'(BUFFER_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clk_noc) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_fifo_count   <= '0;
            r_overflow_err <= 1'b0;
            for (int i = 0; i < BUFFER_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_flit_in;
                r_wr_ptr        <= w_wr_ptr_nxt;
            end
            if (w_deq) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_push, w_deq})
                2'b10:   r_fifo_count <= r_fifo_count + 1'b1;
                2'b01:   r_fifo_count <= r_fifo_count - 1'b1;
                default: r_fifo_count <= r_fifo_count;
            endcase
            if (send_in && !w_push) begin
                r_overflow_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_noc) begin
        if (!rst_n) begin
            r_credit_count <= CW'(DOWNSTREAM_CREDITS);
            r_credit_err   <= 1'b0;
        end else begin
            case ({w_deq, credit_in})
                2'b10: r_credit_count <= r_credit_count - 1'b1;
                2'b01: begin
                    if (r_credit_count == CW'(DOWNSTREAM_CREDITS)) begin
                        r_credit_err <= 1'b1;
                    end else begin
                        r_credit_count <= r_credit_count + 1'b1;
                    end
                end
                default: r_credit_count <= r_credit_count;
            endcase
        end
    end

    generate
        if (NUM_PIPELINE == 0) begin : g_comb
            assign send_out    = w_deq;
            assign credit_out  = w_deq;
            assign data_out    = w_head[EW-1 -: FLIT_WIDTH];
            assign dest_out    = w_head[DEST_WIDTH:1];
            assign is_tail_out = w_head[0];
        end else begin : g_pipe
            logic [PS-1:0] r_send;
            logic [PS-1:0] r_credit;
            logic [EW-1:0] r_flit [PS];

            // Payload registers load only with a valid flit so idle stages keep their last value.
            always_ff @(posedge clk_noc) begin
                if (!rst_n) begin
                    r_send   <= '0;
                    r_credit <= '0;
                    for (int i = 0; i < PS; i++) begin
                        r_flit[i] <= '0;
                    end
                end else begin
                    r_send[0]   <= w_deq;
                    r_credit[0] <= w_deq;
                    if (w_deq) begin
                        r_flit[0] <= w_head;
                    end
                    for (int i = 1; i < PS; i++) begin
                        r_send[i]   <= r_send[i-1];
                        r_credit[i] <= r_credit[i-1];
                        if (r_send[i-1]) begin
                            r_flit[i] <= r_flit[i-1];
                        end
                    end
                end
            end

            assign send_out    = r_send[PS-1];
            assign credit_out  = r_credit[PS-1];
            assign data_out    = r_flit[PS-1][EW-1 -: FLIT_WIDTH];
            assign dest_out    = r_flit[PS-1][DEST_WIDTH:1];
            assign is_tail_out = r_flit[PS-1][0];
        end
    endgenerate

    assign credit_count = r_credit_count;
    assign fifo_count   = r_fifo_count;
    assign overflow_err = r_overflow_err;
    assign credit_err   = r_credit_err;

endmodule
